// File: rtl/affine_filter_pkg.sv
// Shared constants, coefficient row type and the 16-phase coefficient table for the
// 6-tap affine interpolation filter.
package affine_filter_pkg;

  localparam int unsigned DATA_W    = 11;
  localparam int unsigned COEF_W    = 8;
  localparam int unsigned NTAPS     = 6;
  localparam int unsigned NFRAC     = 16;
  localparam int unsigned PROD_W    = DATA_W + COEF_W;
  localparam int unsigned SUM_W     = PROD_W + 3;
  localparam int          ROUND_OFS = 32;
  localparam int unsigned SHIFT     = 6;
  localparam logic [2:0]  FILL_FULL = 3'd6;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t coef_row_t [NTAPS];

  // Every row sums to 64 so a flat input passes through unchanged.
  localparam coef_row_t COEF [NFRAC] = '{
    '{ 8'sd0,  8'sd0,  8'sd64,  8'sd0,   8'sd0,  8'sd0},
    '{ 8'sd1, -8'sd3,  8'sd63,  8'sd4,  -8'sd2,  8'sd1},
    '{ 8'sd1, -8'sd5,  8'sd62,  8'sd8,  -8'sd3,  8'sd1},
    '{ 8'sd2, -8'sd8,  8'sd60,  8'sd13, -8'sd4,  8'sd1},
    '{ 8'sd2, -8'sd10, 8'sd57,  8'sd19, -8'sd5,  8'sd1},
    '{ 8'sd2, -8'sd11, 8'sd53,  8'sd24, -8'sd6,  8'sd2},
    '{ 8'sd2, -8'sd9,  8'sd47,  8'sd31, -8'sd8,  8'sd1},
    '{ 8'sd3, -8'sd11, 8'sd45,  8'sd34, -8'sd10, 8'sd3},
    '{ 8'sd3, -8'sd11, 8'sd40,  8'sd40, -8'sd11, 8'sd3},
    '{ 8'sd3, -8'sd10, 8'sd35,  8'sd44, -8'sd11, 8'sd3},
    '{ 8'sd2, -8'sd10, 8'sd31,  8'sd48, -8'sd10, 8'sd3},
    '{ 8'sd2, -8'sd8,  8'sd25,  8'sd51, -8'sd9,  8'sd3},
    '{ 8'sd1, -8'sd5,  8'sd19,  8'sd54, -8'sd8,  8'sd3},
    '{ 8'sd1, -8'sd4,  8'sd14,  8'sd57, -8'sd6,  8'sd2},
    '{ 8'sd0, -8'sd3,  8'sd9,   8'sd60, -8'sd4,  8'sd2},
    '{ 8'sd0, -8'sd2,  8'sd4,   8'sd62, -8'sd2,  8'sd2}
  };

endpackage

// File: rtl/affine_round_clip.sv
// Rounds the tap sum to sample precision. AFFINE_CLIP_EN selects saturation to the
// DATA_W signed range; otherwise the low DATA_W bits wrap.
module affine_round_clip
  import affine_filter_pkg::*;
(
  input  logic signed [SUM_W-1:0]  sum_i,
  output logic signed [DATA_W-1:0] data_o
);

  logic signed [SUM_W-1:0] rounded;

  assign rounded = (sum_i + SUM_W'(ROUND_OFS)) >>> SHIFT;

`ifdef AFFINE_CLIP_EN
  localparam logic signed [SUM_W-1:0] MaxVal = SUM_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MinVal = -SUM_W'(2 ** (DATA_W - 1));

  always_comb begin
    data_o = rounded[DATA_W-1:0];
    if (rounded > MaxVal) begin
      data_o = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (rounded < MinVal) begin
      data_o = {1'b1, {(DATA_W - 1){1'b0}}};
    end
  end
`else
  logic unused_rounded_hi;

  assign unused_rounded_hi = ^rounded[SUM_W-1:DATA_W];
  assign data_o            = rounded[DATA_W-1:0];
`endif

endmodule

// File: rtl/affine_filter_stream_11.sv
// Streaming 6-tap affine interpolation filter: sliding window, product stage, round/clip
// stage. Optional output saturation via AFFINE_CLIP_EN (see affine_round_clip).
module affine_filter_stream_11
  import affine_filter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sol,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [3:0]               in_frac,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data
);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  sample_t    win_q  [NTAPS];
  sample_t    win_d  [NTAPS];
  prod_t      prod_q [NTAPS];
  prod_t      prod_d [NTAPS];
  logic [2:0] fill_q, fill_d;
  logic [3:0] frac_q, frac_d;
  logic       launch_q, launch_d;
  logic       s1_valid_q, s1_valid_d;
  logic       out_valid_q, out_valid_d;
  sample_t    out_data_q, out_data_d;

  logic                    enable;
  logic                    accept;
  logic signed [SUM_W-1:0] sum;
  sample_t                 rc_data;

  // One global enable stalls every stage together while the output is held.
  assign enable    = !out_valid_q || out_ready;
  assign accept    = in_valid && enable;
  assign in_ready  = enable;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NTAPS; i++) begin
      sum = sum + SUM_W'(prod_q[i]);
    end
  end

  affine_round_clip u_round_clip (
    .sum_i  (sum),
    .data_o (rc_data)
  );

  always_comb begin
    win_d       = win_q;
    prod_d      = prod_q;
    fill_d      = fill_q;
    frac_d      = frac_q;
    launch_d    = launch_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (enable) begin
      launch_d = 1'b0;
      if (accept) begin
        for (int i = 0; i < NTAPS - 1; i++) begin
          win_d[i] = win_q[i+1];
        end
        win_d[NTAPS-1] = in_data;
        if (in_sol) begin
          fill_d = 3'd1;
        end else if (fill_q != FILL_FULL) begin
          fill_d = fill_q + 3'd1;
        end
        frac_d   = in_frac;
        launch_d = (fill_d == FILL_FULL);
      end
      for (int i = 0; i < NTAPS; i++) begin
        prod_d[i] = PROD_W'(win_q[i]) * PROD_W'(COEF[frac_q][i]);
      end
      s1_valid_d  = launch_q;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = rc_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        win_q[i]  <= '0;
        prod_q[i] <= '0;
      end
      fill_q      <= '0;
      frac_q      <= '0;
      launch_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      win_q       <= win_d;
      prod_q      <= prod_d;
      fill_q      <= fill_d;
      frac_q      <= frac_d;
      launch_q    <= launch_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_affine_filter_stream_11.sv
// Scoreboard bench for affine_filter_stream_11: a line-level reference model queues expected
// outputs; a monitor pops and compares on every output handshake.
module tb_affine_filter_stream_11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sol;
  logic [10:0] in_data;
  logic [3:0]  in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;

  affine_filter_stream_11 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sol    (in_sol),
    .in_data   (in_data),
    .in_frac   (in_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_q[$];
  int seen[$];
  int hist[$];
  int lat_mark  = -1;
  bit check_lat = 1'b0;
  bit rand_ordy = 1'b0;

  int ref_coef [16][6] = '{
    '{0,   0, 64,  0,   0, 0}, '{1,  -3, 63,  4,  -2, 1}, '{1,  -5, 62,  8,  -3, 1},
    '{2,  -8, 60, 13,  -4, 1}, '{2, -10, 57, 19,  -5, 1}, '{2, -11, 53, 24,  -6, 2},
    '{2,  -9, 47, 31,  -8, 1}, '{3, -11, 45, 34, -10, 3}, '{3, -11, 40, 40, -11, 3},
    '{3, -10, 35, 44, -11, 3}, '{2, -10, 31, 48, -10, 3}, '{2,  -8, 25, 51,  -9, 3},
    '{1,  -5, 19, 54,  -8, 3}, '{1,  -4, 14, 57,  -6, 2}, '{0,  -3,  9, 60,  -4, 2},
    '{0,  -2,  4, 62,  -2, 2}
  };

  function automatic int ref_out(input int frac);
    int s;
    int r;
    s = 0;
    for (int i = 0; i < 6; i++) s += hist[i] * ref_coef[frac][i];
    r = (s + 32) >>> 6;
`ifdef AFFINE_CLIP_EN
    if (r > 1023) r = 1023;
    if (r < -1024) r = -1024;
`else
    r = r & 2047;
    if (r > 1023) r -= 2048;
`endif
    return r;
  endfunction

  task automatic model_accept(input bit sol, input int data, input int frac);
    if (sol) hist.delete();
    hist.push_back(data);
    if (hist.size() > 6) void'(hist.pop_front());
    if (hist.size() == 6) begin
      exp_q.push_back(ref_out(frac));
      if (check_lat) begin
        lat_mark  = cyc + 1;
        check_lat = 1'b0;
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic beat(input bit sol, input int data, input int frac, input bit ordy,
                      output bit acc);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sol    = sol;
    in_data   = data[10:0];
    in_frac   = frac[3:0];
    out_ready = ordy;
    #1;
    acc = in_ready;
    if (acc) model_accept(sol, data, frac);
  endtask

  task automatic send(input bit sol, input int data, input int frac);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      beat(sol, data, frac, rand_ordy ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
      tries++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_accept: beat not accepted after %0d cycles", tries);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    in_sol    = 1'($urandom_range(0, 1));
    in_data   = 11'($urandom_range(0, 2047));
    out_ready = rand_ordy ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_sol    = 1'b0;
      out_ready = 1'b1;
      n++;
    end
    repeat (4) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    check_int("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    hist.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_out_valid", int'(out_valid), 0);
    check_int("reset_out_data", int'(out_data), 0);
  endtask

  // Monitor: samples well after the falling edge, once the driver's inputs have settled.
  bit   hold_pend = 1'b0;
  logic [10:0] hold_data;
  int   got_v;
  int   exp_v;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        tests++;
        if (!out_valid || out_data !== hold_data) begin
          fails++;
          $display("FAIL hold: got valid=%0b data=%0d expected valid=1 data=%0d",
                   out_valid, $signed(out_data), $signed(hold_data));
        end
      end
      if (out_valid && lat_mark >= 0) begin
        check_int("latency", cyc - lat_mark, 2);
        lat_mark = -1;
      end
      if (out_valid && out_ready) begin
        got_v = int'($signed(out_data));
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got %0d expected none", got_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (got_v != exp_v) begin
            fails++;
            $display("FAIL scoreboard: got %0d expected %0d", got_v, exp_v);
          end
        end
        seen.push_back(got_v);
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  int ln_d [12];
  int ln_f [12];
  int ref_seq[$];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sol    = 1'b0;
    in_data   = '0;
    in_frac   = '0;
    out_ready = 1'b1;
    do_reset();

    // Flat input, checks first-output latency too.
    seen.delete();
    check_lat = 1'b1;
    for (int b = 0; b < 10; b++) send(b == 0, 100, 5);
    drain();
    check_int("const_count", seen.size(), 5);
    for (int k = 0; k < seen.size(); k++) check_int("const_value", seen[k], 100);

    // Impulse on tap 1.
    seen.delete();
    for (int b = 0; b < 6; b++) send(b == 0, (b == 1) ? 64 : 0, 1);
    for (int b = 0; b < 6; b++) send(b == 0, (b == 1) ? 64 : 0, 15);
    for (int b = 0; b < 6; b++) send(b == 0, (b == 1) ? 64 : 0, 0);
    drain();
    check_int("impulse_count", seen.size(), 3);
    if (seen.size() == 3) begin
      check_int("impulse_f1", seen[0], -3);
      check_int("impulse_f15", seen[1], -2);
      check_int("impulse_f0", seen[2], 0);
    end

    // Ramp at frac 0 passes win[2].
    seen.delete();
    for (int b = 0; b < 8; b++) send(b == 0, b + 1, 0);
    drain();
    check_int("ramp_count", seen.size(), 3);
    for (int k = 0; k < seen.size() && k < 3; k++) check_int("ramp_value", seen[k], k + 3);

    // Overflowing sum.
    seen.delete();
    for (int b = 0; b < 6; b++) send(b == 0, (b == 1) ? -1024 : 1023, 8);
    drain();
    check_int("sat_count", seen.size(), 1);
`ifdef AFFINE_CLIP_EN
    if (seen.size() == 1) check_int("sat_value", seen[0], 1023);
`else
    if (seen.size() == 1) check_int("sat_value", seen[0], -673);
`endif

    // Reset mid-line, then a line without in_sol.
    seen.delete();
    for (int b = 0; b < 4; b++) send(b == 0, 500, 3);
    do_reset();
    for (int b = 0; b < 6; b++) send(1'b0, 7, 3);
    drain();
    check_int("rst_line_count", seen.size(), 1);
    if (seen.size() == 1) check_int("rst_line_value", seen[0], 7);

    // in_sol on the third beat restarts the window.
    seen.delete();
    send(1'b1, 900, 4);
    send(1'b0, 900, 4);
    send(1'b1, 10, 4);
    for (int b = 0; b < 4; b++) send(1'b0, 10, 4);
    drain();
    check_int("sol_restart_early", seen.size(), 0);
    send(1'b0, 10, 4);
    drain();
    check_int("sol_restart_count", seen.size(), 1);
    if (seen.size() == 1) check_int("sol_restart_value", seen[0], 10);

    // Backpressure: same line unstalled, then stalled; sequences must match.
    for (int b = 0; b < 12; b++) begin
      ln_d[b] = int'($urandom_range(0, 2047)) - 1024;
      ln_f[b] = int'($urandom_range(0, 15));
    end
    seen.delete();
    for (int b = 0; b < 12; b++) send(b == 0, ln_d[b], ln_f[b]);
    drain();
    ref_seq = seen;
    seen.delete();
    for (int b = 0; b < 8; b++) send(b == 0, ln_d[b], ln_f[b]);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sol    = 1'b0;
      in_data   = ln_d[8][10:0];
      in_frac   = ln_f[8][3:0];
      out_ready = 1'b0;
      #1;
      check_int("stall_in_ready", int'(in_ready), 0);
    end
    for (int b = 8; b < 12; b++) send(1'b0, ln_d[b], ln_f[b]);
    drain();
    check_int("stall_count", seen.size(), 7);
    for (int k = 0; k < seen.size() && k < ref_seq.size(); k++)
      check_int("stall_vs_unstalled", seen[k], ref_seq[k]);

    // Random lines with gaps, stray in_sol while idle and random backpressure.
    rand_ordy = 1'b1;
    for (int ln = 0; ln < 30; ln++) begin
      int len;
      len = int'($urandom_range(6, 16));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle();
        send(b == 0, int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 15)));
      end
    end
    rand_ordy = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
